// File: rtl/cordic_iter.sv
// Iterative CORDIC: one micro-rotation per clock, rotation (z -> 0) or vectoring (y -> 0) mode.
// Optional CORDIC_GAIN_COMP_EN adds one final cycle scaling x and y by 1/gain (Q24 constant K).
module cordic_iter #(
  parameter int unsigned WID  = 32,
  parameter int unsigned ITER = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WID-1:0] x_in,
  input  logic [WID-1:0] y_in,
  input  logic [WID-1:0] z_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WID-1:0] x_out,
  output logic [WID-1:0] y_out,
  output logic [WID-1:0] z_out
);

  localparam int unsigned IW = 5;
  localparam logic [IW-1:0] LastStep = IW'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StRun, StGain, StDone} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         i_q;
  logic                  mode_q;
  logic signed [WID-1:0] x_q, y_q, z_q;

  logic signed [WID-1:0] x_sh, y_sh, atan_w;
  logic signed [WID-1:0] x_nx, y_nx, z_nx;
  logic                  d_pos;
  logic                  last_step;

  function automatic logic [31:0] atan_lut(input logic [IW-1:0] idx);
    logic [31:0] val;
    val = 32'd0;
    case (idx)
      5'd0: val = 32'h00C90FDA;
      5'd1: val = 32'h0076B19C;
      5'd2: val = 32'h003EB6EB;
      5'd3: val = 32'h001FD5BA;
      5'd4: val = 32'h000FFAAD;
      5'd5: val = 32'h0007FF55;
      5'd6: val = 32'h0003FFEA;
      5'd7: val = 32'h0001FFFD;
      default: begin
        // Beyond i = 7 atan(2^-i) is 2^-i to within an LSB of the Q24 grid.
        if (idx < 5'd24) val = (32'd1 << (5'd24 - idx)) - 32'd1;
        else             val = 32'd0;
      end
    endcase
    return val;
  endfunction

  always_comb begin
    x_sh      = x_q >>> i_q;
    y_sh      = y_q >>> i_q;
    atan_w    = WID'(atan_lut(i_q));
    d_pos     = mode_q ? y_q[WID-1] : ~z_q[WID-1];
    x_nx      = d_pos ? (x_q - y_sh) : (x_q + y_sh);
    y_nx      = d_pos ? (y_q + x_sh) : (y_q - x_sh);
    z_nx      = d_pos ? (z_q - atan_w) : (z_q + atan_w);
    last_step = (i_q == LastStep);
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int unsigned PW = WID + 25;
  localparam logic signed [PW-1:0] GainK = PW'(32'h009B74EE);
  localparam logic signed [PW-1:0] Half  = PW'(32'h00800000);

  logic signed [PW-1:0]  x_prod, y_prod, x_rnd, y_rnd;
  logic signed [WID-1:0] x_gain, y_gain;
  logic                  unused_prod_bits;

  always_comb begin
    x_prod = $signed({{25{x_q[WID-1]}}, x_q}) * GainK;
    y_prod = $signed({{25{y_q[WID-1]}}, y_q}) * GainK;
    x_rnd  = (x_prod + Half) >>> 24;
    y_rnd  = (y_prod + Half) >>> 24;
    x_gain = x_rnd[WID-1:0];
    y_gain = y_rnd[WID-1:0];
  end
  assign unused_prod_bits = ^{x_rnd[PW-1:WID], y_rnd[PW-1:WID]};
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StRun;
      end
      StRun: begin
        if (last_step) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = StGain;
`else
          state_d = StDone;
`endif
        end
      end
      StGain: state_d = StDone;
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      x_out   <= '0;
      y_out   <= '0;
      z_out   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mode_q <= mode;
            x_q    <= x_in;
            y_q    <= y_in;
            z_q    <= z_in;
            i_q    <= '0;
          end
        end
        StRun: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          i_q <= i_q + 1'b1;
`ifndef CORDIC_GAIN_COMP_EN
          if (last_step) begin
            x_out <= x_nx;
            y_out <= y_nx;
            z_out <= z_nx;
          end
`endif
        end
        StGain: begin
`ifdef CORDIC_GAIN_COMP_EN
          x_out <= x_gain;
          y_out <= y_gain;
          z_out <= z_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter: latency, handshake, backpressure, mid-run reset and accuracy
// against an ideal floating-point rotation/vectoring result scaled by the expected output gain.
module tb_cordic_iter;

  localparam int unsigned WID  = 32;
  localparam int unsigned ITER = 24;
  localparam real Q  = 16777216.0;
  localparam real An = 1.6467602581210656;
  localparam real Kq = 10188014.0 / 16777216.0;
  localparam longint Tol = 32;
`ifdef CORDIC_GAIN_COMP_EN
  localparam longint ExpLat  = ITER + 2;
  localparam real    OutGain = An * Kq;
`else
  localparam longint ExpLat  = ITER + 1;
  localparam real    OutGain = An;
`endif

  logic           clk = 1'b0;
  logic           rst, mode, in_valid, in_ready, out_valid, out_ready;
  logic [WID-1:0] x_in, y_in, z_in, x_out, y_out, z_out;

  int n_checks = 0;
  int n_errors = 0;

  cordic_iter #(.WID(WID), .ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint diff;
    n_checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
               tag, got, got, exp, exp, tol);
    end
  endtask

  function automatic longint rnd(input real r);
    return longint'(r);
  endfunction

  // Ideal result: exact rotation/vectoring with the CORDIC gain seen at the outputs.
  task automatic model(input logic m, input longint xv, input longint yv, input longint zv,
                       output longint ex, output longint ey, output longint ez);
    real xr, yr, zr;
    xr = real'(xv) / Q;
    yr = real'(yv) / Q;
    zr = real'(zv) / Q;
    if (!m) begin
      ex = rnd((xr * $cos(zr) - yr * $sin(zr)) * OutGain * Q);
      ey = rnd((yr * $cos(zr) + xr * $sin(zr)) * OutGain * Q);
      ez = 0;
    end else begin
      ex = rnd($sqrt(xr * xr + yr * yr) * OutGain * Q);
      ey = 0;
      ez = rnd((zr + $atan2(yr, xr)) * Q);
    end
  endtask

  task automatic do_op(input string tag, input logic m, input longint xv, input longint yv,
                       input longint zv, input bit scramble, input int hold);
    int     cyc;
    longint ex, ey, ez;
    model(m, xv, yv, zv, ex, ey, ez);
    check({tag, " ready_before"}, longint'(in_ready), 1, 0);
    mode     = m;
    x_in     = xv[WID-1:0];
    y_in     = yv[WID-1:0];
    z_in     = zv[WID-1:0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc      = 0;
    while (!out_valid && cyc < 200) begin
      if (scramble) begin
        in_valid = 1'($urandom_range(0, 1));
        mode     = 1'($urandom_range(0, 1));
        x_in     = $urandom;
        y_in     = $urandom;
        z_in     = $urandom;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, longint'(cyc + 1), ExpLat, 0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, " hold_valid"}, longint'(out_valid), 1, 0);
      check({tag, " hold_ready"}, longint'(in_ready), 0, 0);
      check({tag, " hold_x"}, longint'($signed(x_out)), ex, Tol);
      check({tag, " hold_y"}, longint'($signed(y_out)), ey, Tol);
    end
    check({tag, " x"}, longint'($signed(x_out)), ex, Tol);
    check({tag, " y"}, longint'($signed(y_out)), ey, Tol);
    check({tag, " z"}, longint'($signed(z_out)), ez, Tol);
    check({tag, " ready_in_done"}, longint'(in_ready), 0, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " ready_after"}, longint'(in_ready), 1, 0);
    check({tag, " valid_after"}, longint'(out_valid), 0, 0);
  endtask

  initial begin
    int vcount;
    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst in_ready", longint'(in_ready), 1, 0);
    check("rst out_valid", longint'(out_valid), 0, 0);
    check("rst x_out", longint'($signed(x_out)), 0, 0);
    check("rst y_out", longint'($signed(y_out)), 0, 0);
    check("rst z_out", longint'($signed(z_out)), 0, 0);

    do_op("rot_pi4", 1'b0, 64'h009B74EE, 0, 64'h00C90FDA, 1'b0, 0);
    do_op("rot_m_pi4", 1'b0, 64'h009B74EE, 0, -64'sh0036_0FDA - 64'sh0093_0000, 1'b0, 0);
    do_op("vec_45", 1'b1, 64'h01000000, 64'h01000000, 0, 1'b0, 0);
    do_op("rot_z0", 1'b0, 64'h00800000, 64'h00400000, 0, 1'b0, 0);
    do_op("rot_pi2", 1'b0, 64'h00400000, 0, 64'h01921FB5, 1'b0, 0);
    do_op("vec_negy", 1'b1, 64'h00300000, -64'sh00400000, 64'h00100000, 1'b0, 0);
    do_op("backpress", 1'b0, 64'h00800000, 64'h00400000, 64'h00200000, 1'b0, 10);
    do_op("scramble", 1'b0, 64'h00800000, 64'h00400000, 0, 1'b1, 0);

    // Abort an operation at RUN step 12 with a reset pulse.
    mode     = 1'b0;
    x_in     = 32'h009B74EE;
    y_in     = '0;
    z_in     = 32'h00C90FDA;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst in_ready", longint'(in_ready), 1, 0);
    check("midrst out_valid", longint'(out_valid), 0, 0);
    check("midrst x_out", longint'($signed(x_out)), 0, 0);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) vcount++;
    end
    check("midrst no_valid", longint'(vcount), 0, 0);
    do_op("after_rst", 1'b0, 64'h009B74EE, 0, 64'h00C90FDA, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cordic_iter.md
CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 SHALL have parameter WID, default 32: signed width of x, y and z (z is radians, 24 fraction bits); legal 28..40.
REQ-002 SHALL have parameter ITER, default 24: micro-rotations per operation; legal 1..32.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 SHALL have port mode, input, 1: 0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
REQ-006 SHALL have port in_valid, input, 1: operands valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept operands.
REQ-008 SHALL have ports x_in, y_in, z_in, input, WID each: signed operands.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have ports x_out, y_out, z_out, output, WID each: signed results.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 SHALL capture mode, x_in, y_in, z_in and clear step counter i to 0 on in_valid & in_ready, then enter RUN.
REQ-014 In RUN, SHALL perform one micro-rotation per cycle for i = 0..ITER-1, then enter DONE; latency from accept to out_valid = ITER+1 cycles (flag off).
REQ-015 Rotation: d = +1 if z >= 0, else -1. Vectoring: d = +1 if y < 0, else -1.
REQ-016 Micro-rotation: x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_i. Shifts are arithmetic; arithmetic wraps modulo 2^WID.
REQ-017 atan_i SHALL come from an internal table, sign-extended to WID.
- i = 0..7: 0x00C90FDA, 0x0076B19C, 0x003EB6EB, 0x001FD5BA, 0x000FFAAD, 0x0007FF55, 0x0003FFEA, 0x0001FFFD.
- i = 8..23: 2^(24-i) - 1.
- i >= 24: 0.
REQ-018 Outputs SHALL be registered and hold stable in DONE until out_ready = 1; that cycle returns to IDLE.
REQ-019 in_ready SHALL rise the cycle after the DONE->IDLE handshake; there is no same-cycle output/input overlap.
REQ-020 in_valid SHALL be ignored outside IDLE; operand/mode changes during RUN SHALL NOT affect the result.
REQ-021 Input range (|x|, |y| < 2^(WID-3); |z| <= pi/2) is a caller obligation; out-of-range inputs wrap silently with no error flag.

Reset
REQ-022 When rst = 1 at a clk edge, the block SHALL go to IDLE and clear: out_valid = 0; in_ready = 1 after that edge; x_out, y_out, z_out and i = 0.
REQ-023 Reset mid-RUN or mid-DONE SHALL discard the operation with no out_valid pulse.

Configuration
REQ-024 Macro CORDIC_GAIN_COMP_EN defined: after the last iteration, the block SHALL spend one extra cycle (latency ITER+2) multiplying x and y by K = 0x009B74EE (Q24, 0.607253).
- The product is rounded to nearest and truncated to WID.
- z is unchanged.
REQ-025 Macro undefined: the multiplier and the extra cycle are absent; x_out and y_out carry the raw CORDIC gain (about 1.64676).

Verification (WID = 32, ITER = 24; tolerance ±32 LSB)
REQ-026 Rotation, flag off: x = 0x009B74EE, y = 0, z = 0x00C90FDA -> x_out ≈ y_out ≈ 0x00B504F3, z_out ≈ 0; out_valid exactly 25 cycles after accept.
REQ-027 Vectoring, flag on: x = y = 0x01000000, z = 0 -> z_out ≈ 0x00C90FDA, x_out ≈ 0x016A09E6, y_out ≈ 0; latency 26 cycles.
REQ-028 Backpressure: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready = 0 throughout; in_ready = 1 the cycle after out_ready is asserted.
REQ-029 Reset at RUN step 12 -> IDLE next cycle; out_valid never asserts; the next operation gives the correct result.
REQ-030 Rotation x = 0x009B74EE, y = 0, z = 0xFF36F026 (-pi/4) -> x_out ≈ 0x00B504F3, y_out ≈ 0xFF4AFB0D.
REQ-031 in_valid toggled with changing operands during RUN -> result matches the first captured operands only.
